auto_player: RTL and testbench

//  Parametrised auto-play sequencer for the buzzer music box. Steps through a

---
 rtl/music_pkg.sv | 27 ++
 rtl/btn_edge.sv | 29 ++
 rtl/auto_player.sv | 145 ++++++++++++++
 tb/tb_auto_player.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// music_pkg : shared note codes, sequencer state encoding, LED decode helper
// Revision  : 1.0
// ============================================================================
package music_pkg;

    localparam logic [3:0] REST_NOTE     = 4'h0;
    localparam logic [3:0] END_NOTE_CODE = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        PLAY  = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Note n in 1..led_w lights bit n-1; rest, end marker and out-of-range codes stay dark.
    function automatic logic [31:0] led_onehot(input int unsigned note,
                                               input int unsigned led_w,
                                               input int unsigned end_note);
        if (note >= 1 && note <= led_w && note <= 32 && note != end_note)
            return 32'd1 << (note - 1);
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// btn_edge : two-flop synchroniser with single-cycle rising-edge pulse
// Revision : 1.0
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [1:0] r_sync;
    logic       r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn};
            r_last <= r_sync[1];
        end
    end

    assign pulse = r_sync[1] & ~r_last;

endmodule
`default_nettype wire

// File: rtl/auto_player.sv
`default_nettype none
// ============================================================================
// auto_player : song-ROM sequencer with note durations, gaps, pause, song select
// Revision    : 1.0
// ============================================================================
module auto_player
    import music_pkg::*;
#(
    parameter int                CLK_PER_UNIT = 10_000_000,
    parameter int                SONG_LEN     = 56,
    parameter int                NUM_SONGS    = 3,
    parameter int                NOTE_W       = 4,
    parameter int                DUR_W        = 4,
    parameter int                LED_W        = 7,
    parameter int                GAP_CYCLES   = 500_000,
    parameter logic [NOTE_W-1:0] END_NOTE     = NOTE_W'(END_NOTE_CODE),
    localparam int               SONG_W       = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int               ADDR_W       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_btn,
    input  logic              prev_btn,
    input  logic              pause,
    output logic [SONG_W-1:0] song_num,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    input  logic [DUR_W-1:0]  rom_dur,
    output logic [NOTE_W-1:0] note_to_play,
    output logic [LED_W-1:0]  led_out,
    output logic              playing
);

    localparam int                c_cyc_w     = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
    localparam int                c_gap_w     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_cyc_w-1:0] c_cyc_last  = c_cyc_w'(CLK_PER_UNIT - 1);
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0]  c_addr_last = ADDR_W'(SONG_LEN - 1);
    localparam logic [SONG_W-1:0]  c_song_last = SONG_W'(NUM_SONGS - 1);

    state_t              r_state, w_state_nxt;
    logic [c_cyc_w-1:0]  r_cyc;
    logic [c_gap_w-1:0]  r_gap;
    logic [DUR_W-1:0]    r_units;
    logic [NOTE_W-1:0]   r_note;
    logic [LED_W-1:0]    r_led;
    logic [SONG_W-1:0]   r_song;
    logic [ADDR_W-1:0]   r_addr;

    logic w_next_p, w_prev_p, w_jump;
    logic w_unit_done, w_note_done, w_gap_done, w_is_end, w_advance;

    btn_edge u_next (.clk(clk), .reset(reset), .btn(next_btn), .pulse(w_next_p));
    btn_edge u_prev (.clk(clk), .reset(reset), .btn(prev_btn), .pulse(w_prev_p));

    // Simultaneous next and prev cancel each other out.
    assign w_jump      = w_next_p ^ w_prev_p;
    assign w_unit_done = (r_cyc == c_cyc_last);
    assign w_note_done = w_unit_done && (r_units <= DUR_W'(1));
    assign w_gap_done  = (r_gap == c_gap_last);
    assign w_is_end    = (rom_note == END_NOTE);
    assign w_advance   = !pause && (((r_state == PLAY) && w_note_done && (GAP_CYCLES == 0)) ||
                                    ((r_state == GAP) && w_gap_done));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_jump) begin
            w_state_nxt = FETCH;
        end else if (!pause) begin
            case (r_state)
                FETCH:   if (!w_is_end) w_state_nxt = PLAY;
                PLAY:    if (w_note_done) w_state_nxt = (GAP_CYCLES > 0) ? GAP : FETCH;
                GAP:     if (w_gap_done) w_state_nxt = FETCH;
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_song  <= '0;
            r_addr  <= '0;
            r_cyc   <= '0;
            r_gap   <= '0;
            r_units <= '0;
            r_note  <= '0;
            r_led   <= '0;
        end else if (w_jump) begin
            if (w_next_p) r_song <= (r_song == c_song_last) ? '0 : r_song + 1'b1;
            else          r_song <= (r_song == '0) ? c_song_last : r_song - 1'b1;
            r_addr  <= '0;
            r_cyc   <= '0;
            r_gap   <= '0;
            r_units <= '0;
            r_note  <= '0;
            r_led   <= '0;
        end else if (!pause) begin
            case (r_state)
                FETCH: begin
                    if (w_is_end) begin
                        r_addr <= '0;
                    end else begin
                        r_note  <= rom_note;
                        r_led   <= LED_W'(led_onehot(int'(rom_note), LED_W, int'(END_NOTE)));
                        r_units <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                        r_cyc   <= '0;
                    end
                end
                PLAY: begin
                    if (w_unit_done) begin
                        r_cyc   <= '0;
                        r_units <= r_units - 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                GAP:     r_gap <= w_gap_done ? '0 : r_gap + 1'b1;
                default: ;
            endcase
            if (w_advance) r_addr <= (r_addr == c_addr_last) ? '0 : r_addr + 1'b1;
        end
    end

    // LED stays lit through a pause; the buzzer goes silent.
    always_comb begin
        note_to_play = NOTE_W'(REST_NOTE);
        led_out      = '0;
        playing      = 1'b0;
        if (r_state == PLAY) begin
            playing = 1'b1;
            led_out = r_led;
            if (!pause) note_to_play = r_note;
        end
    end

    assign song_num = r_song;
    assign rom_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_auto_player.sv
`default_nettype none
// ============================================================================
// tb_auto_player : table-driven song selection plus random ROM/pause scoreboard
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_auto_player;

    localparam int CPU  = 4;
    localparam int GAPC = 2;
    localparam int SLEN = 8;
    localparam int NS   = 3;
    localparam int LW   = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       next_btn = 1'b0;
    logic       prev_btn = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] song_num;
    logic [2:0] rom_addr;
    logic [3:0] rom_note, rom_dur, note_to_play;
    logic [6:0] led_out;
    logic       playing;

    logic [3:0] rom_n [4][SLEN];
    logic [3:0] rom_d [4][SLEN];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int note;
        int addr;
        bit play;
    } samp_t;
    samp_t q[$];

    typedef struct {
        bit nxt;
        bit prv;
        int exp_song;
        bit acts;
        int pstart;
        bit rnd;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    assign rom_note = rom_n[song_num][rom_addr];
    assign rom_dur  = rom_d[song_num][rom_addr];

    auto_player #(
        .CLK_PER_UNIT(CPU),
        .SONG_LEN    (SLEN),
        .NUM_SONGS   (NS),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .next_btn    (next_btn),
        .prev_btn    (prev_btn),
        .pause       (pause),
        .song_num    (song_num),
        .rom_addr    (rom_addr),
        .rom_note    (rom_note),
        .rom_dur     (rom_dur),
        .note_to_play(note_to_play),
        .led_out     (led_out),
        .playing     (playing)
    );

    function automatic int exp_led(input int n);
        if (n >= 1 && n <= LW) return 1 << (n - 1);
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected per-cycle view of a song, starting with the first note after its fetch.
    task automatic build_model(input int s, input int n);
        int a;
        int u;
        bit first;
        a = 0;
        first = 1'b1;
        q.delete();
        while (q.size() < n) begin
            if (!first) q.push_back('{0, a, 1'b0});
            first = 1'b0;
            if (rom_n[s][a] == 4'hF) begin
                a = 0;
                continue;
            end
            u = (rom_d[s][a] == 4'h0) ? 1 : int'(rom_d[s][a]);
            repeat (u * CPU) q.push_back('{int'(rom_n[s][a]), a, 1'b1});
            repeat (GAPC) q.push_back('{0, a, 1'b0});
            a = (a == SLEN - 1) ? 0 : a + 1;
        end
    endtask

    task automatic run_timeline(input int s, input int n, input int pstart,
                                input int plen, input bit rnd);
        samp_t cur;
        bit    pz;
        build_model(s, n);
        cur = '{0, 0, 1'b0};
        for (int i = 0; i < n; i++) begin
            pz = (i >= pstart && i < pstart + plen) || (rnd && $urandom_range(0, 7) == 0);
            pause = pz;
            @(negedge clk);
            if (!pz) cur = q.pop_front();
            check($sformatf("note s%0d c%0d", s, i), int'(note_to_play), pz ? 0 : cur.note);
            check($sformatf("led s%0d c%0d", s, i), int'(led_out), exp_led(cur.note));
            check($sformatf("addr s%0d c%0d", s, i), int'(rom_addr), cur.addr);
            check($sformatf("playing s%0d c%0d", s, i), int'(playing), int'(cur.play));
            check($sformatf("song s%0d c%0d", s, i), int'(song_num), s);
        end
        pause = 1'b0;
    endtask

    task automatic press(input bit n, input bit p, input int exp_song, input bit acts);
        next_btn = 1'b0;
        prev_btn = 1'b0;
        @(negedge clk);
        next_btn = n;
        prev_btn = p;
        repeat (3) @(negedge clk);
        check("btn_song", int'(song_num), exp_song);
        if (acts) begin
            check("btn_addr", int'(rom_addr), 0);
            check("btn_note", int'(note_to_play), 0);
            check("btn_led", int'(led_out), 0);
            check("btn_playing", int'(playing), 0);
        end
        next_btn = 1'b0;
        prev_btn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rom_n[0] = '{4'd3, 4'd5, 4'd0, 4'd7, 4'd9, 4'hF, 4'd1, 4'd2};
        rom_d[0] = '{4'd2, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
        for (int a = 0; a < SLEN; a++) begin
            rom_n[1][a] = 4'($urandom_range(1, 14));
            rom_d[1][a] = 4'($urandom_range(0, 3));
            rom_n[2][a] = 4'($urandom_range(0, 15));
            rom_d[2][a] = 4'($urandom_range(0, 2));
            rom_n[3][a] = 4'h0;
            rom_d[3][a] = 4'h0;
        end

        vecs[0] = '{1'b1, 1'b0, 1, 1'b1, 1000, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2, 1'b1, 1000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 0, 1'b1, 5,    1'b0};
        vecs[3] = '{1'b0, 1'b1, 2, 1'b1, 1000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 2, 1'b0, 1000, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1, 1'b1, 1000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 0, 1'b1, 1000, 1'b1};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_note", int'(note_to_play), 0);
            check("rst_led", int'(led_out), 0);
            check("rst_song", int'(song_num), 0);
            check("rst_addr", int'(rom_addr), 0);
            check("rst_playing", int'(playing), 0);
        end
        reset = 1'b1;

        run_timeline(0, 60, 1000, 0, 1'b0);

        foreach (vecs[i]) begin
            press(vecs[i].nxt, vecs[i].prv, vecs[i].exp_song, vecs[i].acts);
            if (vecs[i].acts)
                run_timeline(vecs[i].exp_song, 45, vecs[i].pstart, 10, vecs[i].rnd);
        end

        // Holding next must produce exactly one song step.
        next_btn = 1'b0;
        @(negedge clk);
        next_btn = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_song_early", int'(song_num), 1);
        repeat (45) @(negedge clk);
        check("hold_song_late", int'(song_num), 1);
        next_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_song_release", int'(song_num), 1);

        w = 0;
        while (!(playing && note_to_play != 4'h0) && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("wait_note_bound", int'(w < 40), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_note", int'(note_to_play), 0);
        check("midrst_led", int'(led_out), 0);
        check("midrst_song", int'(song_num), 0);
        check("midrst_addr", int'(rom_addr), 0);
        check("midrst_playing", int'(playing), 0);
        repeat (2) @(negedge clk);
        check("midrst_hold_song", int'(song_num), 0);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
